// File: rtl/ram_port_sequencer_if.sv
// ram_port_sequencer_if: host request/response channel of the RAM port sequencer
interface ram_port_sequencer_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    modport master (
        output req_valid, req_op, req_addr, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );
    modport slave (
        input  req_valid, req_op, req_addr, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/ram_port_sequencer.sv
// ram_port_sequencer: drives a read-first single-port RAM for read/write/add/clear requests
module ram_port_sequencer #(
    parameter int                ADDR_W     = 6,
    parameter int                DATA_W     = 16,
    parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
    input  logic                CLK,
    input  logic                RST_n,
    ram_port_sequencer_if.slave host,
    output logic                init_done,
    output logic                ram_en,
    output logic                ram_we,
    output logic [ADDR_W-1:0]   ram_address,
    output logic [DATA_W-1:0]   ram_DI,
    input  logic [DATA_W-1:0]   ram_DO
);
    typedef enum logic [2:0] {INIT, IDLE, CAP, RMW, RESP} state_t;
    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] opnd;
    logic [1:0]        op;
    logic              acc;
    logic              wb;
    assign acc            = state == IDLE && host.req_valid;
    assign wb             = state == RMW && op == 2'd2;
    assign host.req_ready = state == IDLE;
    // RAM port is combinational from state and held quiet while in reset
    always_comb begin
        ram_en      = RST_n && (state == INIT || acc || wb);
        ram_we      = RST_n && (state == INIT || (acc && host.req_op[0]) || wb);
        ram_address = !RST_n ? '0 : state == INIT ? cnt : acc ? host.req_addr : wb ? addr : '0;
        ram_DI      = !RST_n ? '0 :
                      state == INIT ? INIT_VALUE :
                      acc ? (host.req_op == 2'd1 ? host.req_data :
                             host.req_op == 2'd3 ? INIT_VALUE : '0) :
                      wb ? ram_DO + opnd : '0;
    end
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state          <= INIT;
            cnt            <= '0;
            addr           <= '0;
            opnd           <= '0;
            op             <= '0;
            init_done      <= 1'b0;
            host.rsp_valid <= 1'b0;
            host.rsp_data  <= '0;
        end else begin
            case (state)
                INIT: begin
                    cnt <= cnt == '1 ? cnt : cnt + ADDR_W'(1);
                    if (cnt == '1) begin
                        state     <= IDLE;
                        init_done <= 1'b1;
                    end
                end
                IDLE: if (host.req_valid) begin
                    op    <= host.req_op;
                    addr  <= host.req_addr;
                    opnd  <= host.req_data;
                    state <= host.req_op == 2'd2 ? RMW : CAP;
                end
                CAP, RMW: begin
                    host.rsp_data  <= ram_DO;
                    host.rsp_valid <= 1'b1;
                    state          <= RESP;
                end
                RESP: if (host.rsp_ready) begin
                    host.rsp_valid <= 1'b0;
                    state          <= IDLE;
                end
                default: state <= INIT;
            endcase
        end
    end
endmodule
